// File: rtl/framebuffer_scanout.sv
// Scans a 1-bpp word-organised frame buffer out as a raster with sync and data-enable.
// Two-stage output pipeline: read issue -> word load/shift -> registered video outputs.
module framebuffer_scanout #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 48,
  parameter int unsigned H_BP     = 40,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 13,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 29
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  output logic        rd_en_o,
  output logic [15:0] rd_address_o,
  input  logic [15:0] rd_data_i,
  output logic        pixel_o,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        frame_done_o
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HAct    = 11'(H_ACTIVE);
  localparam logic [10:0] VAct    = 11'(V_ACTIVE);
  localparam logic [10:0] HLast   = 11'(HTotal - 1);
  localparam logic [10:0] VLast   = 11'(VTotal - 1);
  localparam logic [10:0] HsStart = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HsEnd   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VsStart = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VsEnd   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] Wpl     = 16'(H_ACTIVE / 16);

  typedef enum logic [0:0] {StWait, StRun} state_e;

  state_e      state_q, state_d;
  logic [10:0] h_q, h_d, v_q, v_d;
  logic [15:0] line_base_q, line_base_d;
  logic        rd_en_d;
  logic [15:0] rd_address_d;
  logic        h_last, v_last, run;

  // Stage-1 video flags; ld1_q marks the cycle rd_data_i carries a fresh word.
  logic        de1_q, hs1_q, vs1_q, fd1_q, ld1_q;
  logic        de1_d, hs1_d, vs1_d, fd1_d;
  logic [15:0] shift_q, shift_d;
  logic        pixel_d;

  assign h_last = (h_q == HLast);
  assign v_last = (v_q == VLast);
  assign run    = (state_q == StRun);

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    v_d         = v_q;
    line_base_d = line_base_q;
    unique case (state_q)
      StWait: begin
        h_d         = '0;
        v_d         = '0;
        line_base_d = '0;
        if (!load_i) state_d = StRun;
      end
      StRun: begin
        if (h_last) begin
          h_d = '0;
          if (v_last) begin
            v_d         = '0;
            line_base_d = '0;
            if (load_i) state_d = StWait;
          end else begin
            v_d = v_q + 11'd1;
            if (v_q < VAct) line_base_d = line_base_q + Wpl;
          end
        end else begin
          h_d = h_q + 11'd1;
        end
      end
      default: state_d = StWait;
    endcase
  end

  // Read strobe is registered from next-state counters so it lines up with (h,v) in cycle t.
  always_comb begin
    rd_en_d      = (state_d == StRun) && (h_d < HAct) && (v_d < VAct) && (h_d[3:0] == 4'd0);
    rd_address_d = rd_en_d ? (line_base_d + {9'd0, h_d[10:4]}) : rd_address_o;
  end

  always_comb begin
    de1_d   = run && (h_q < HAct) && (v_q < VAct);
    hs1_d   = !(run && (h_q >= HsStart) && (h_q < HsEnd));
    vs1_d   = !(run && (v_q >= VsStart) && (v_q < VsEnd));
    fd1_d   = run && h_last && v_last;
    shift_d = ld1_q ? rd_data_i : {shift_q[14:0], 1'b0};
    // shift_q[14] is the bit after the one presented last cycle.
    pixel_d = de1_q && (ld1_q ? rd_data_i[15] : shift_q[14]);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StWait;
      h_q          <= '0;
      v_q          <= '0;
      line_base_q  <= '0;
      rd_en_o      <= 1'b0;
      rd_address_o <= '0;
      de1_q        <= 1'b0;
      hs1_q        <= 1'b1;
      vs1_q        <= 1'b1;
      fd1_q        <= 1'b0;
      ld1_q        <= 1'b0;
      shift_q      <= '0;
      pixel_o      <= 1'b0;
      de_o         <= 1'b0;
      hsync_o      <= 1'b1;
      vsync_o      <= 1'b1;
      frame_done_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      v_q          <= v_d;
      line_base_q  <= line_base_d;
      rd_en_o      <= rd_en_d;
      rd_address_o <= rd_address_d;
      de1_q        <= de1_d;
      hs1_q        <= hs1_d;
      vs1_q        <= vs1_d;
      fd1_q        <= fd1_d;
      ld1_q        <= rd_en_o;
      shift_q      <= shift_d;
      pixel_o      <= pixel_d;
      de_o         <= de1_q;
      hsync_o      <= hs1_q;
      vsync_o      <= vs1_q;
      frame_done_o <= fd1_q;
    end
  end

endmodule
